// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: default parameters and the IF/ID bundle.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          ROM_AW_DEF   = 6;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES   = 32'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_CLEAR = '{
        valid:    1'b0,
        instr:    32'h0000_0000,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000
    };

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register for the IF/ID bundle with capture, hold and flush control.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   capture,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_r;

    // Flush only kills the valid bit; the payload is don't-care once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= IF_ID_CLEAR;
        end else if (flush) begin
            q_r.valid <= 1'b0;
        end else if (capture) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the combinational ROM and fills IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ROM_AW   = ROM_AW_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_dout,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_plus4,
    output logic [31:0]       pc,
    output logic              fetch_fault
);

    logic [31:0] pc_r;
    logic        fault_r;
    logic [31:0] pc_plus4_s;
    logic        adv_s;
    logic        in_range_s;
    if_id_t      id_d_s;
    if_id_t      id_q_s;

    assign pc_plus4_s = pc_r + WORD_BYTES;
    assign adv_s      = !id_q_s.valid || id_ready;
    // Any bit above the ROM byte span means the fetch falls outside the ROM.
    assign in_range_s = (pc_r >> (ROM_AW + 2)) == 32'd0;
    assign rom_addr   = pc_r[ROM_AW+1:2];

    // Assemble the word headed for IF/ID; out-of-range fetches become NOPs.
    always_comb begin
        id_d_s          = IF_ID_CLEAR;
        id_d_s.valid    = 1'b1;
        id_d_s.instr    = in_range_s ? rom_dout : NOP_WORD;
        id_d_s.pc       = pc_r;
        id_d_s.pc_plus4 = pc_plus4_s;
    end

    // PC update: redirect beats advance, otherwise hold for the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= {redirect_pc[31:2], 2'b00};
        end else if (adv_s) begin
            pc_r <= pc_plus4_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (adv_s),
        .flush   (redirect_valid),
        .d       (id_d_s),
        .q       (id_q_s)
    );

    assign if_valid    = id_q_s.valid;
    assign if_instr    = id_q_s.instr;
    assign if_pc       = id_q_s.pc;
    assign if_pc_plus4 = id_q_s.pc_plus4;
    assign pc          = pc_r;
    assign fetch_fault = fault_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  rom_addr;
    logic [31:0] rom_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] pc;
    logic        fetch_fault;

    logic [31:0] rom_mem [64];
    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_ifpc, m_p4;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    assign rom_dout = rom_mem[rom_addr];

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .pc             (pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_p4 = 32'h0;
        m_valid = 1'b0; m_fault = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk({tag, ".instr"}, if_instr, m_instr);
            chk({tag, ".if_pc"}, if_pc, m_ifpc);
            chk({tag, ".pc_plus4"}, if_pc_plus4, m_p4);
        end
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".rom_addr"}, {26'd0, rom_addr}, {26'd0, m_pc[7:2]});
        chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, m_fault});
    endtask

    // One clock: drive inputs, advance the model with the fetch rules, compare at negedge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy, input string tag);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        if (rv) begin
            m_pc    = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            if (rpc % 4 != 0) m_fault = 1'b1;
        end else if (!m_valid || rdy) begin
            m_instr = (m_pc / 4 < 64) ? rom_mem[m_pc / 4] : 32'h0000_0000;
            m_ifpc  = m_pc;
            m_p4    = m_pc + 4;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
        end
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        logic [31:0] held_instr, held_pc;
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'h0000_0000;
        rom_mem[0]  = 32'h0000_3f37;
        rom_mem[1]  = 32'h0200_0fe7;
        rom_mem[2]  = 32'h01c0_2623;
        rom_mem[7]  = 32'h0000_0fef;
        rom_mem[8]  = 32'h0000_1c63;
        rom_mem[13] = 32'hfc00_0ae3;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        model_reset();
        @(negedge clk);
        check_model("reset");
        chk("reset.instr", if_instr, 32'h0);
        chk("reset.if_pc", if_pc, 32'h0);
        chk("reset.p4", if_pc_plus4, 32'h0);
        rst_n = 1'b1;

        step(1'b0, 32'h0, 1'b1, "seq1");
        chk("seq1.instr_c", if_instr, 32'h0000_3f37);
        chk("seq1.p4_c", if_pc_plus4, 32'h4);
        step(1'b0, 32'h0, 1'b1, "seq2");
        chk("seq2.instr_c", if_instr, 32'h0200_0fe7);

        step(1'b1, 32'h20, 1'b1, "redir");
        chk("redir.valid_c", {31'd0, if_valid}, 32'd0);
        chk("redir.pc_c", pc, 32'h20);
        step(1'b0, 32'h0, 1'b1, "redir_f");
        chk("redir_f.instr_c", if_instr, 32'h0000_1c63);

        step(1'b1, 32'h8, 1'b1, "to8");
        step(1'b0, 32'h0, 1'b1, "at8");
        chk("at8.instr_c", if_instr, 32'h01c0_2623);
        held_instr = if_instr;
        held_pc = pc;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, "stall");
            chk("stall.instr_c", if_instr, held_instr);
            chk("stall.pc_c", pc, held_pc);
        end
        step(1'b0, 32'h0, 1'b1, "rel0");
        chk("rel0.if_pc_c", if_pc, 32'hC);
        step(1'b0, 32'h0, 1'b1, "rel1");
        chk("rel1.if_pc_c", if_pc, 32'h10);

        step(1'b1, 32'h8, 1'b0, "stall_redir");
        chk("stall_redir.valid_c", {31'd0, if_valid}, 32'd0);
        step(1'b0, 32'h0, 1'b0, "stall_redir_f");
        chk("stall_redir_f.instr_c", if_instr, 32'h01c0_2623);

        step(1'b1, 32'h22, 1'b1, "mis");
        chk("mis.fault_c", {31'd0, fetch_fault}, 32'd1);
        step(1'b0, 32'h0, 1'b1, "mis_f");
        chk("mis_f.instr_c", if_instr, 32'h0000_1c63);
        chk("mis_f.if_pc_c", if_pc, 32'h20);

        step(1'b1, 32'h100, 1'b1, "oor");
        step(1'b0, 32'h0, 1'b1, "oor_f");
        chk("oor_f.instr_c", if_instr, 32'h0);
        chk("oor_f.if_pc_c", if_pc, 32'h100);

        step(1'b1, 32'hFFFF_FFFC, 1'b1, "wrap");
        step(1'b0, 32'h0, 1'b1, "wrap_f");
        chk("wrap_f.p4_c", if_pc_plus4, 32'h0);
        chk("wrap_f.pc_c", pc, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom_range(0, 99) < 15);
            rpc = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
            step(rv, rpc, 1'($urandom_range(0, 1)), "rand");
        end

        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        chk("async_rst.instr", if_instr, 32'h0);
        chk("async_rst.if_pc", if_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 9) == 0), 32'($urandom_range(0, 120)) & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), "post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM, which has a 6-bit word address, 32-bit data and is combinational.
- Owns the program counter, drives the ROM address and captures the returned word into the IF/ID pipeline register.
- Handles redirects from branches and jumps resolved downstream, stalls from decode, and out-of-range or misaligned fetches.
- Output feeds the decode stage through a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_AW, 6, ROM word-address width; ROM covers byte addresses 0 to (4<<ROM_AW)-1.
- NOP_WORD, 32'h0000_0000, word injected for out-of-range fetches; matches the ROM default.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- rom_addr, output, ROM_AW, word address, equal to pc[ROM_AW+1:2].
- rom_dout, input, 32, instruction word from the ROM (combinational).
- redirect_valid, input, 1, taken branch/jal/jalr from execute.
- redirect_pc, input, 32, redirect target byte address.
- id_ready, input, 1, decode can accept the IF/ID contents this cycle.
- if_valid, output, 1, IF/ID register holds a valid instruction.
- if_instr, output, 32, fetched instruction.
- if_pc, output, 32, byte address of if_instr.
- if_pc_plus4, output, 32, if_pc+4, the link value for jal/jalr.
- pc, output, 32, current fetch PC (debug).
- fetch_fault, output, 1, sticky flag for a misaligned redirect target.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_pc_plus4=0; fetch_fault=0.
  - Reset asserted mid-operation discards in-flight state immediately.
- Datapath:
  - rom_addr is driven combinationally from pc.
  - The ROM word is captured into IF/ID on the same edge that advances pc.
  - Latency: PC to if_instr is 1 cycle; sustained throughput is 1 instruction per cycle.
- Out-of-range fetch: if pc >= 4<<ROM_AW, the captured word is NOP_WORD and if_valid is still 1.
- Advance condition: adv = !if_valid | id_ready.
- Priority per edge, highest first:
  1. redirect_valid=1:
     - pc<=redirect_pc with bits [1:0] forced to 0.
     - if_valid<=0, flushing the wrong-path word.
     - Applies regardless of id_ready.
     - If redirect_pc[1:0]!=0, fetch_fault<=1 (sticky until reset); the fetch still proceeds at the aligned address.
  2. adv=1:
     - if_instr<=rom_word, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1.
     - pc<=pc+4.
  3. Otherwise (stall): pc and the IF/ID register hold.
- Redirect and stall in the same cycle: the redirect wins. The held instruction is dropped, and decode must not consume it, because execute resolving a redirect implies the older instruction is wrong-path.
- Arithmetic: pc+4 wraps modulo 2^32 with no flag. 32'hFFFF_FFFC+4 gives 0.
- Self-loop (e.g. jal x31,0): the repeated redirect to the same pc produces one bubble per iteration. This is legal; there is no deadlock.
- Control: the only sequential control is the valid/stall handshake above. There is no multi-cycle FSM because the ROM is single-cycle.

Decomposition:
- Shared package, owned here and imported by decode:
  - RESET_PC default
  - NOP_WORD
  - ROM_AW
  - word-offset constant 4
  - if_id bundle typedef {valid, instr, pc, pc_plus4}
- One sub-module, if_id_reg:
  - IF/ID register carrying capture, hold and flush control.
  - Reused later for the ID/EX bundle.
- PC generation and the range check stay in fetch_stage.

Test Plan:
Program image: word0=0000_3f37, word1=0200_0fe7, word2=01c0_2623, word7=0000_0fef, word8=0000_1c63, word13=fc00_0ae3.
- Reset release with id_ready=1 held:
  - Cycle 1: if_instr=0000_3f37, if_pc=0, if_pc_plus4=4, if_valid=1.
  - Cycle 2: 0200_0fe7, if_pc=4.
  - pc increments by 4 every cycle.
- Redirect to 32'h20 while if_pc=4:
  - Next edge: if_valid=0, pc=20.
  - Following edge: if_instr=0000_1c63, if_pc=20, if_pc_plus4=24.
- Stall: id_ready=0 for 3 cycles while if_instr=01c0_2623 (if_pc=8):
  - if_valid, if_instr, if_pc and pc stable for all 3 cycles.
  - On release, 0c and then 10 follow with no skip or duplicate.
- Stall plus redirect to 32'h08 in the same cycle:
  - Held word is dropped; next edge if_valid=0, pc=8.
  - Then if_instr=01c0_2623.
- Misaligned redirect to 32'h22:
  - fetch_fault=1 and stays 1.
  - Fetch proceeds at 20 with 0000_1c63.
- Out-of-range redirect to 32'h100 (ROM_AW=6):
  - if_instr=0000_0000, if_valid=1, if_pc=100.
- Async reset mid-stream:
  - rst_n low between clock edges clears all outputs immediately.
  - pc=RESET_PC.
